uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
//  Drains the TX FIFO into the UART transmitter core, one frame at a time.
//  - Pops a byte when the FIFO is non-empty and the transmitter is idle.
//  - Issues a one-cycle start pulse with the byte held stable.
//  - Waits for frame completion, then enforces a programmable inter-frame idle gap.
//  - Sits between fifo (TX instance) and uart_tx inside the UART IP top.
// PARAMETERS
//  SIZE_DATA   8    width of FIFO data / UART frame payload
//  GAP_CYCLES  0    idle clocks inserted after each i_tx_done (0 = back-to-back)
//  CNT_W       16   width of sent-frame counter
// PORTS
//  i_clk         in   1          system clock
//  i_rst_n       in   1          reset; synchronous, active-low
//  i_enable      in   1          1 = scheduler may pop FIFO; 0 = finish current frame, then hold
//  i_fifo_empty  in   1          from FIFO o_fifo_empty
//  o_fifo_rd_en  out  1          to FIFO i_en_rd; one-cycle pulse per pop
//  i_fifo_data   in   SIZE_DATA  from FIFO o_data; valid the cycle after o_fifo_rd_en
//  o_tx_start    out  1          one-cycle start pulse to uart_tx
//  o_tx_data     out  SIZE_DATA  byte to transmit; held from START until next pop
//  i_tx_busy     in   1          uart_tx frame in progress
//  i_tx_done     in   1          uart_tx one-cycle pulse at end of stop bit
//  o_busy        out  1          1 whenever state != IDLE
//  o_frame_cnt   out  CNT_W      frames completed (counts i_tx_done in WAIT); wraps
// BEHAVIOUR
//  - Reset: synchronous, active-low; all outputs 0, state IDLE, gap counter 0.
//    - Reset mid-frame returns to IDLE at once; uart_tx is not aborted.
//    - A later i_tx_done is ignored (arrives while IDLE).
//  - FSM, one transition per clock:
//    - IDLE:  i_enable & !i_fifo_empty & !i_tx_busy -> READ.
//    - READ:  o_fifo_rd_en=1 for exactly this cycle -> FETCH.
//    - FETCH: register i_fifo_data into o_tx_data -> START.
//    - START: o_tx_start=1 for exactly this cycle -> WAIT.
//    - WAIT:  on i_tx_done, o_frame_cnt+=1 -> GAP if GAP_CYCLES>0, else IDLE.
//    - GAP:   count GAP_CYCLES clocks, then -> IDLE.
//  - Latency: FIFO non-empty in IDLE -> o_tx_start asserted 3 clocks later (READ, FETCH, START).
//  - Never pops while i_fifo_empty=1 (empty sampled in IDLE only; one pop per frame).
//    - Guarantees no underflow.
//  - i_enable deassert mid-frame: current frame completes incl. gap; no further pop.
//  - i_tx_done outside WAIT: ignored; i_tx_busy only gates IDLE->READ.
//  - o_frame_cnt wraps 2^CNT_W-1 -> 0 silently.
//  - FIFO write side is independent; simultaneous external write and our pop is legal.
// CONFIGURATION
//  - Macro UART_TX_SCHED_FLUSH_EN defined: adds port i_flush (in, 1).
//    - i_flush=1 in IDLE with FIFO non-empty -> FLUSH state.
//    - FLUSH: o_fifo_rd_en=1 every cycle while !i_fifo_empty; no o_tx_start.
//    - Leave FLUSH for IDLE when i_fifo_empty=1; o_frame_cnt unchanged.
//    - i_flush has priority over a normal pop in IDLE.
//  - Macro undefined: no i_flush port, no FLUSH state; behaviour exactly as above.
// STRUCTURE
//  - uart_pkg holds:
//    - typedef enum logic [2:0] tx_sched_state_t {IDLE,READ,FETCH,START,WAIT,GAP,FLUSH}.
//    - localparam GAP_W = $clog2(GAP_CYCLES+1).
//  - Single module, no sub-modules; one state register, one gap counter, one frame counter.
// TESTING (bench instantiates fifo SIZE_DEPTH=16 + behavioural uart_tx model)
//  1. Reset: hold i_rst_n=0 2 clks -> all outputs 0, o_busy=0, o_frame_cnt=0.
//  2. Write 0xA5 to empty FIFO, i_enable=1, GAP=0 -> o_tx_start 3 clks after empty falls.
//     Expect o_tx_data=0xA5, exactly one o_fifo_rd_en, o_frame_cnt=1 after i_tx_done.
//  3. Write 0..15 (full) -> 16 start pulses, bytes 0..15 in order, FIFO empty after the last.
//     Expect no rd_en while empty, o_frame_cnt=16.
//  4. GAP_CYCLES=4, two bytes -> second o_tx_start exactly 4+3 clks after first i_tx_done.
//  5. i_enable=0 during frame 1 of 3 -> frame 1 completes, o_busy falls.
//     Expect 2 bytes left in FIFO; re-enable sends remaining 2.
//  6. FLUSH_EN build: 5 bytes queued, pulse i_flush in IDLE.
//     Expect 5 consecutive rd_en, FIFO empty, no o_tx_start, o_frame_cnt unchanged.
//     Also: reset asserted in WAIT -> IDLE next clk; late i_tx_done ignored.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART IP: TX scheduler state encoding and gap-counter sizing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        FETCH,
        START,
        WAIT,
        GAP,
        FLUSH
    } tx_sched_state_t;

    // Gap counter width, GAP_W = $clog2(GAP_CYCLES+1), kept at least 1 bit so GAP_CYCLES=0 still elaborates
    function automatic int gap_width(input int gap_cycles);
        return (gap_cycles < 1) ? 1 : $clog2(gap_cycles + 1);
    endfunction

endpackage

// File: rtl/uart_tx_sched.sv
// Moves TX FIFO bytes into uart_tx one frame at a time, with a programmable idle gap after each frame.
// Optional UART_TX_SCHED_FLUSH_EN adds i_flush, which discards the FIFO contents without transmitting.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int SIZE_DATA  = 8,
    parameter int GAP_CYCLES = 0,
    parameter int CNT_W      = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_enable,
    input  logic                 i_fifo_empty,
    output logic                 o_fifo_rd_en,
    input  logic [SIZE_DATA-1:0] i_fifo_data,
    output logic                 o_tx_start,
    output logic [SIZE_DATA-1:0] o_tx_data,
    input  logic                 i_tx_busy,
    input  logic                 i_tx_done,
`ifdef UART_TX_SCHED_FLUSH_EN
    input  logic                 i_flush,
`endif
    output logic                 o_busy,
    output logic [CNT_W-1:0]     o_frame_cnt
);

    localparam int GAP_W = gap_width(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    tx_sched_state_t  state;
    logic [GAP_W-1:0] gap_cnt;
    logic             rd_pulse;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            rd_pulse    <= 1'b0;
            o_tx_start  <= 1'b0;
            o_tx_data   <= '0;
            o_busy      <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            rd_pulse   <= 1'b0;
            o_tx_start <= 1'b0;
            case (state)
                IDLE: begin
`ifdef UART_TX_SCHED_FLUSH_EN
                    if (i_flush && !i_fifo_empty) begin
                        state  <= FLUSH;
                        o_busy <= 1'b1;
                    end else
`endif
                    if (i_enable && !i_fifo_empty && !i_tx_busy) begin
                        state    <= READ;
                        rd_pulse <= 1'b1;
                        o_busy   <= 1'b1;
                    end
                end
                READ: begin
                    state <= FETCH;
                end
                // FIFO read data is valid in this cycle, one clock after the pop
                FETCH: begin
                    o_tx_data  <= i_fifo_data;
                    o_tx_start <= 1'b1;
                    state      <= START;
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (i_tx_done) begin
                        o_frame_cnt <= o_frame_cnt + CNT_W'(1);
                        if (GAP_CYCLES > 0) begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end else begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state   <= IDLE;
                        gap_cnt <= '0;
                        o_busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
`ifdef UART_TX_SCHED_FLUSH_EN
                FLUSH: begin
                    if (i_fifo_empty) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
`endif
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    // Flush pops follow the live empty flag so the final pop never lands on an empty FIFO
`ifdef UART_TX_SCHED_FLUSH_EN
    assign o_fifo_rd_en = rd_pulse | ((state == FLUSH) & ~i_fifo_empty);
`else
    assign o_fifo_rd_en = rd_pulse;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: two instances (GAP_CYCLES=0 and 4), each with a FIFO model and a uart_tx model.
// Build with +define+UART_TX_SCHED_FLUSH_EN to also exercise the flush feature.
module tb_uart_tx_sched;

    localparam int N     = 2;
    localparam int FRAME = 10;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        en       [N];
    logic        empty    [N];
    logic        rd_en    [N];
    logic [7:0]  fdata    [N] = '{8'h00, 8'h00};
    logic        start    [N];
    logic [7:0]  tx_data  [N];
    logic        tx_busy  [N] = '{1'b0, 1'b0};
    logic        tx_done  [N] = '{1'b0, 1'b0};
    logic        busy     [N];
    logic [15:0] fcnt     [N];
`ifdef UART_TX_SCHED_FLUSH_EN
    logic        flush    [N];
`endif

    logic        wr       [N];
    logic [7:0]  wdata    [N];
    logic [7:0]  mem      [N][DEPTH];
    int          fcount   [N] = '{0, 0};
    int          rp       [N] = '{0, 0};
    int          wp       [N] = '{0, 0};
    int          ucnt     [N] = '{0, 0};

    int          rd_cnt   [N] = '{0, 0};
    int          start_cnt[N] = '{0, 0};
    int          underflow[N] = '{0, 0};
    int          run      [N] = '{0, 0};
    int          maxrun   [N] = '{0, 0};
    logic [7:0]  sent[$];

    int n_chk = 0;
    int n_err = 0;

    for (genvar g = 0; g < N; g++) begin : env
        uart_tx_sched #(
            .SIZE_DATA (8),
            .GAP_CYCLES((g == 0) ? 0 : 4),
            .CNT_W     (16)
        ) dut (
            .i_clk       (clk),
            .i_rst_n     (rst_n),
            .i_enable    (en[g]),
            .i_fifo_empty(empty[g]),
            .o_fifo_rd_en(rd_en[g]),
            .i_fifo_data (fdata[g]),
            .o_tx_start  (start[g]),
            .o_tx_data   (tx_data[g]),
            .i_tx_busy   (tx_busy[g]),
            .i_tx_done   (tx_done[g]),
`ifdef UART_TX_SCHED_FLUSH_EN
            .i_flush     (flush[g]),
`endif
            .o_busy      (busy[g]),
            .o_frame_cnt (fcnt[g])
        );
    end

    always_comb begin
        for (int g = 0; g < N; g++) empty[g] = (fcount[g] == 0);
    end

    // FIFO model: registered read data, valid the cycle after the pop
    always @(posedge clk) begin
        for (int g = 0; g < N; g++) begin
            int pop, push;
            pop  = (rd_en[g] && fcount[g] != 0) ? 1 : 0;
            push = (wr[g] && (fcount[g] < DEPTH || pop == 1)) ? 1 : 0;
            if (pop == 1) begin
                fdata[g] <= mem[g][rp[g]];
                rp[g]    <= (rp[g] + 1) % DEPTH;
            end
            if (push == 1) begin
                mem[g][wp[g]] <= wdata[g];
                wp[g]         <= (wp[g] + 1) % DEPTH;
            end
            fcount[g] <= fcount[g] + push - pop;
        end
    end

    // uart_tx model: busy for FRAME clocks after start, then a one-cycle done pulse
    always @(posedge clk) begin
        for (int g = 0; g < N; g++) begin
            tx_done[g] <= 1'b0;
            if (start[g]) begin
                tx_busy[g] <= 1'b1;
                ucnt[g]    <= FRAME;
            end else if (tx_busy[g]) begin
                if (ucnt[g] == 1) begin
                    tx_busy[g] <= 1'b0;
                    tx_done[g] <= 1'b1;
                end
                ucnt[g] <= ucnt[g] - 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (rd_en[g]) rd_cnt[g] <= rd_cnt[g] + 1;
            if (rd_en[g] && empty[g]) underflow[g] <= underflow[g] + 1;
            run[g] <= rd_en[g] ? run[g] + 1 : 0;
            if (rd_en[g] && run[g] + 1 > maxrun[g]) maxrun[g] <= run[g] + 1;
            if (start[g]) begin
                start_cnt[g] <= start_cnt[g] + 1;
                if (g == 0) sent.push_back(tx_data[0]);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic push(input int g, input logic [7:0] d);
        @(negedge clk);
        wr[g]    = 1'b1;
        wdata[g] = d;
        @(negedge clk);
        wr[g]    = 1'b0;
    endtask

    // Clocks from the current falling edge until o_tx_start is seen (100 = never)
    task automatic wait_start(input int g, output int n);
        n = 0;
        while (start[g] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_done(input int g, output int n);
        n = 0;
        while (tx_done[g] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_frames(input int g, input int val);
        int n;
        n = 0;
        while (fcnt[g] != 16'(val) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_wait_timeout", (n < 2000) ? 1 : 0, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rb, sb, base;
        rst_n = 1'b0;
        for (int g = 0; g < N; g++) begin
            en[g] = 1'b0;
            wr[g] = 1'b0;
            wdata[g] = 8'h00;
`ifdef UART_TX_SCHED_FLUSH_EN
            flush[g] = 1'b0;
`endif
        end

        // reset held for two clocks
        tick(2);
        for (int g = 0; g < N; g++) begin
            chk("rst_rd_en", rd_en[g], 0);
            chk("rst_tx_start", start[g], 0);
            chk("rst_tx_data", tx_data[g], 0);
            chk("rst_busy", busy[g], 0);
            chk("rst_frame_cnt", fcnt[g], 0);
        end
        rst_n = 1'b1;

        // single byte, back-to-back build
        en[0] = 1'b1;
        rb = rd_cnt[0];
        push(0, 8'hA5);
        wait_start(0, n);
        chk("empty_fall_to_start", n, 3);
        chk("single_data", tx_data[0], 8'hA5);
        chk("single_rd_count", rd_cnt[0] - rb, 1);
        wait_frames(0, 1);
        chk("single_frame_cnt", fcnt[0], 1);
        tick(3);
        chk("single_busy_idle", busy[0], 0);
        chk("single_rd_once", rd_cnt[0] - rb, 1);

        // two bytes through the 4-cycle gap instance
        en[1] = 1'b0;
        push(1, 8'h3C);
        push(1, 8'hC3);
        en[1] = 1'b1;
        wait_start(1, n);
        chk("gap_first_data", tx_data[1], 8'h3C);
        wait_done(1, n);
        @(negedge clk);
        wait_start(1, n);
        chk("gap4_done_to_start", n, 7);
        chk("gap_second_data", tx_data[1], 8'hC3);
        wait_frames(1, 2);
        chk("gap_frame_cnt", fcnt[1], 2);
        en[1] = 1'b0;

        // full FIFO, 16 frames in order
        do_reset();
        en[0] = 1'b0;
        base = sent.size();
        rb = rd_cnt[0];
        for (int i = 0; i < 16; i++) push(0, 8'(i));
        chk("full_fifo_level", fcount[0], 16);
        en[0] = 1'b1;
        wait_start(0, n);
        wait_done(0, n);
        @(negedge clk);
        wait_start(0, n);
        chk("gap0_done_to_start", n, 3);
        wait_frames(0, 16);
        tick(3);
        chk("burst_frame_cnt", fcnt[0], 16);
        chk("burst_fifo_empty", fcount[0], 0);
        chk("burst_rd_count", rd_cnt[0] - rb, 16);
        chk("burst_no_underflow", underflow[0], 0);
        chk("burst_sent_count", sent.size() - base, 16);
        for (int i = 0; i < 16; i++) begin
            if (base + i < sent.size()) chk("burst_order", sent[base + i], i);
        end

        // enable dropped during frame 1 of 3
        do_reset();
        en[0] = 1'b0;
        rb = rd_cnt[0];
        push(0, 8'h11);
        push(0, 8'h22);
        push(0, 8'h33);
        en[0] = 1'b1;
        wait_start(0, n);
        en[0] = 1'b0;
        n = 0;
        while (busy[0] !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("hold_busy_fell", busy[0], 0);
        chk("hold_frame_cnt", fcnt[0], 1);
        tick(5);
        chk("hold_fifo_left", fcount[0], 2);
        chk("hold_rd_count", rd_cnt[0] - rb, 1);
        en[0] = 1'b1;
        wait_frames(0, 3);
        chk("resume_frame_cnt", fcnt[0], 3);
        chk("resume_last_data", sent[sent.size() - 1], 8'h33);
        tick(2);
        chk("resume_fifo_empty", fcount[0], 0);

        // reset while waiting for frame completion
        do_reset();
        en[0] = 1'b1;
        push(0, 8'h5A);
        wait_start(0, n);
        tick(2);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy[0], 0);
        chk("midrst_tx_data", tx_data[0], 0);
        chk("midrst_frame_cnt", fcnt[0], 0);
        rst_n = 1'b1;
        wait_done(0, n);
        chk("late_done_seen", (n < 100) ? 1 : 0, 1);
        tick(3);
        chk("late_done_ignored", fcnt[0], 0);
        chk("late_done_busy", busy[0], 0);
        en[0] = 1'b0;

`ifdef UART_TX_SCHED_FLUSH_EN
        // flush five queued bytes; flush wins over the simultaneous normal pop
        do_reset();
        for (int i = 0; i < 5; i++) push(0, 8'(8'hE0 + i));
        rb = rd_cnt[0];
        sb = start_cnt[0];
        @(negedge clk);
        flush[0] = 1'b1;
        en[0]    = 1'b1;
        @(negedge clk);
        flush[0] = 1'b0;
        en[0]    = 1'b0;
        tick(10);
        chk("flush_rd_count", rd_cnt[0] - rb, 5);
        chk("flush_rd_run", maxrun[0], 5);
        chk("flush_no_start", start_cnt[0] - sb, 0);
        chk("flush_fifo_empty", fcount[0], 0);
        chk("flush_frame_cnt", fcnt[0], 0);
        chk("flush_busy", busy[0], 0);
        chk("flush_no_underflow", underflow[0], 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
